// File: rtl/mdu_ctrl.sv
// Iterative unsigned multiply/divide unit for a MIPS-style HI/LO register.
// Shift-add MULTU and restoring DIVU, one radix-2 step per cycle over 32 cycles.
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        we_hilo,
  output logic [63:0] hilo_d,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic        op_r;
  logic [31:0] a_r, b_r;
  logic [63:0] acc;
  logic [32:0] rem;
  logic        dbz;

  logic        accept;
  logic        div_zero_req;
  logic        last_iter;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;
  logic [63:0] acc_next;
  logic [32:0] rem_next;

  assign div_zero_req = op && (b == 32'd0);
  assign last_iter    = (state == RUN) && (cnt == 5'd31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = div_zero_req ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    we_hilo     = done;
    div_by_zero = done && dbz;
  end

  // One iteration: MULTU keeps {partial product, multiplier} in acc;
  // DIVU keeps the dividend/quotient in acc[31:0] and the remainder in rem.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, a_r};
    shifted  = {rem[31:0], acc[31]};
    ge       = rem[32] || (shifted >= {1'b0, b_r});
    acc_next = acc;
    rem_next = rem;
    if (!op_r) begin
      acc_next = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
    end else begin
      rem_next = ge ? (shifted - {1'b0, b_r}) : shifted;
      acc_next = {acc[63:32], acc[30:0], ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 5'd0;
      op_r   <= 1'b0;
      a_r    <= 32'd0;
      b_r    <= 32'd0;
      acc    <= 64'd0;
      rem    <= 33'd0;
      dbz    <= 1'b0;
      hilo_d <= 64'd0;
    end else if (accept) begin
      cnt  <= 5'd0;
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
      acc  <= {32'd0, (op ? a : b)};
      rem  <= 33'd0;
      dbz  <= div_zero_req;
      if (div_zero_req) hilo_d <= {a, 32'hFFFF_FFFF};
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      acc <= acc_next;
      rem <= rem_next;
      // hilo_d only changes on completion, so partial results never leak out
      if (last_iter) hilo_d <= op_r ? {rem_next[31:0], acc_next[31:0]} : acc_next;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected results computed with
// plain arithmetic; an independent monitor checks every done pulse and idle cycle.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, we_hilo, div_by_zero;
  logic [63:0] hilo_d;

  typedef struct {
    logic [63:0] hilo;
    logic        dbz;
    int          due;
  } expect_t;

  expect_t     sb[$];
  logic [63:0] held = 64'd0;
  int          cycle = 0;
  int          compared = 0;
  int          mismatched = 0;

  mdu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .we_hilo(we_hilo), .hilo_d(hilo_d),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic expect_t model(input logic o, input logic [31:0] x, input logic [31:0] y, input int due);
    expect_t e;
    e.due = due;
    e.dbz = 1'b0;
    if (!o) begin
      e.hilo = {32'd0, x} * {32'd0, y};
    end else if (y == 32'd0) begin
      e.hilo = {x, 32'hFFFF_FFFF};
      e.dbz  = 1'b1;
    end else begin
      e.hilo = {x % y, x / y};
    end
    return e;
  endfunction

  // Issue an operation in the first cycle the unit is idle and record its expected result.
  task automatic applyStimulus(input logic o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    int acc_edge;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (busy) checkOutput("idle_timeout", 64'(busy), 64'd0);
    start = 1'b1; op = o; a = x; b = y;
    acc_edge = cycle + 1;
    sb.push_back(model(o, x, y, acc_edge + ((o && y == 32'd0) ? 0 : 32)));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("done_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic waitCycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Scoreboard monitor: every done pulse pops one expectation; idle cycles must hold the last result.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          expect_t e;
          e = sb.pop_front();
          checkOutput("hilo_d", hilo_d, e.hilo);
          checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          checkOutput("we_hilo", 64'(we_hilo), 64'd1);
          checkOutput("done_cycle", 64'(cycle), 64'(e.due));
          held = e.hilo;
        end
      end else begin
        checkOutput("hold_hilo_d", hilo_d, held);
        checkOutput("idle_we_hilo", 64'(we_hilo), 64'd0);
        checkOutput("idle_div_by_zero", 64'(div_by_zero), 64'd0);
      end
    end
  end

  initial begin
    logic        r_op;
    logic [31:0] r_a, r_b;
    $display("[TB] mdu_ctrl scoreboard bench starting");
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_hilo_d", hilo_d, 64'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd7, 32'd6);
    drain();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    applyStimulus(1'b1, 32'd100, 32'd7);
    applyStimulus(1'b1, 32'd7, 32'd100);
    drain();
    applyStimulus(1'b1, 32'd5, 32'd0);
    drain();

    // A start raised mid-operation must be ignored.
    applyStimulus(1'b0, 32'd3, 32'd4);
    waitCycles(9);
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Asynchronous reset in the middle of an operation aborts it.
    applyStimulus(1'b0, 32'd5, 32'd9);
    waitCycles(9);
    #2 rst = 1'b1;
    sb.delete();
    held = 64'd0;
    #1;
    checkOutput("async_reset_busy", 64'(busy), 64'd0);
    checkOutput("async_reset_done", 64'(done), 64'd0);
    checkOutput("async_reset_hilo_d", hilo_d, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    applyStimulus(1'b0, 32'd2, 32'd3);
    drain();

    for (int i = 0; i < 40; i++) begin
      r_op = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: r_a = $urandom_range(0, 255);
        1: r_a = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: r_b = 32'd0;
        1: r_b = $urandom_range(1, 15);
        2: r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      applyStimulus(r_op, r_a, r_b);
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();
    waitCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
